// File: rtl/pipe_pkg.sv
// Shared widths, ALU codes and the per-stage control record for the EXE/MEM/WB chain.
package pipe_pkg;

  localparam int unsigned RN_W   = 5;
  localparam int unsigned ALUC_W = 4;

  localparam logic [RN_W-1:0] LINK_REG = 5'd31;

  localparam logic [ALUC_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALUC_W-1:0] ALU_SUB = 4'b0100;
  localparam logic [ALUC_W-1:0] ALU_AND = 4'b0001;
  localparam logic [ALUC_W-1:0] ALU_OR  = 4'b0101;
  localparam logic [ALUC_W-1:0] ALU_XOR = 4'b0010;
  localparam logic [ALUC_W-1:0] ALU_LUI = 4'b0110;
  localparam logic [ALUC_W-1:0] ALU_SLL = 4'b0011;
  localparam logic [ALUC_W-1:0] ALU_SRL = 4'b0111;
  localparam logic [ALUC_W-1:0] ALU_SRA = 4'b1111;

  typedef struct packed {
    logic            wreg;
    logic            m2reg;
    logic            wmem;
    logic [RN_W-1:0] rn;
    logic            valid;
  } stage_ctrl_t;

  function automatic logic [RN_W-1:0] dest_rn(input logic            jal,
                                             input logic            regrt,
                                             input logic [RN_W-1:0] rt,
                                             input logic [RN_W-1:0] rd);
    logic [RN_W-1:0] rn;
    rn = regrt ? rt : rd;
    if (jal) rn = LINK_REG;
    return rn;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Reset-to-zero pipeline register for one stage's control record; bubble_i loads all zeros.
module pipe_stage_reg
  import pipe_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        bubble_i,
  input  stage_ctrl_t d_i,
  output stage_ctrl_t q_o
);

  stage_ctrl_t ctrl_d, ctrl_q;

  always_comb begin
    ctrl_d = d_i;
    if (bubble_i) ctrl_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign q_o = ctrl_q;

endmodule

// File: rtl/pipe_ctrl_chain.sv
// ID->EXE->MEM->WB control chain with bubble insertion on load-use stall.
// Optional perf counters (stall/retire) are built only when PIPE_PERF_EN is defined.
module pipe_ctrl_chain
  import pipe_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              wpcir,
  input  logic              wreg,
  input  logic              m2reg,
  input  logic              wmem,
  input  logic              jal,
  input  logic              regrt,
  input  logic              aluimm,
  input  logic              shift,
  input  logic [ALUC_W-1:0] aluc,
  input  logic [RN_W-1:0]   rt,
  input  logic [RN_W-1:0]   rd,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic              ejal,
  output logic              ealuimm,
  output logic              eshift,
  output logic [ALUC_W-1:0] ealuc,
  output logic [RN_W-1:0]   ern,
  output logic              mwreg,
  output logic              mm2reg,
  output logic              mwmem,
  output logic [RN_W-1:0]   mrn,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [RN_W-1:0]   wrn,
  output logic              evalid,
  output logic              mvalid,
  output logic              wvalid,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       retire_cnt
);

  logic            bubble;
  logic [RN_W-1:0] drn;
  stage_ctrl_t     id_ctrl, exe_q, mem_d, mem_q, wb_d, wb_q;

  assign bubble = ~wpcir;
  assign drn    = dest_rn(jal, regrt, rt, rd);

  // Non-writing instructions carry rn=0 so downstream forwarding compares never match.
  always_comb begin
    id_ctrl       = '0;
    id_ctrl.wreg  = wreg;
    id_ctrl.m2reg = m2reg;
    id_ctrl.wmem  = wmem;
    id_ctrl.rn    = wreg ? drn : '0;
    id_ctrl.valid = 1'b1;
  end

  pipe_stage_reg u_exe_reg (
    .clk_i    (clock),
    .rst_ni   (resetn),
    .bubble_i (bubble),
    .d_i      (id_ctrl),
    .q_o      (exe_q)
  );

  // EXE-only controls that never travel further down the chain.
  logic              ejal_d, ejal_q;
  logic              ealuimm_d, ealuimm_q;
  logic              eshift_d, eshift_q;
  logic [ALUC_W-1:0] ealuc_d, ealuc_q;

  always_comb begin
    ejal_d    = jal;
    ealuimm_d = aluimm;
    eshift_d  = shift;
    ealuc_d   = aluc;
    if (bubble) begin
      ejal_d    = 1'b0;
      ealuimm_d = 1'b0;
      eshift_d  = 1'b0;
      ealuc_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ejal_q    <= 1'b0;
      ealuimm_q <= 1'b0;
      eshift_q  <= 1'b0;
      ealuc_q   <= '0;
    end else begin
      ejal_q    <= ejal_d;
      ealuimm_q <= ealuimm_d;
      eshift_q  <= eshift_d;
      ealuc_q   <= ealuc_d;
    end
  end

  assign mem_d = exe_q;

  pipe_stage_reg u_mem_reg (
    .clk_i    (clock),
    .rst_ni   (resetn),
    .bubble_i (1'b0),
    .d_i      (mem_d),
    .q_o      (mem_q)
  );

  always_comb begin
    wb_d      = mem_q;
    wb_d.wmem = 1'b0;
  end

  pipe_stage_reg u_wb_reg (
    .clk_i    (clock),
    .rst_ni   (resetn),
    .bubble_i (1'b0),
    .d_i      (wb_d),
    .q_o      (wb_q)
  );

  logic unused_wb_wmem;
  assign unused_wb_wmem = wb_q.wmem;

  assign ewreg   = exe_q.wreg;
  assign em2reg  = exe_q.m2reg;
  assign ewmem   = exe_q.wmem;
  assign ern     = exe_q.rn;
  assign evalid  = exe_q.valid;
  assign ejal    = ejal_q;
  assign ealuimm = ealuimm_q;
  assign eshift  = eshift_q;
  assign ealuc   = ealuc_q;

  assign mwreg  = mem_q.wreg;
  assign mm2reg = mem_q.m2reg;
  assign mwmem  = mem_q.wmem;
  assign mrn    = mem_q.rn;
  assign mvalid = mem_q.valid;

  assign wwreg  = wb_q.wreg;
  assign wm2reg = wb_q.m2reg;
  assign wrn    = wb_q.rn;
  assign wvalid = wb_q.valid;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] retire_cnt_d, retire_cnt_q;

  always_comb begin
    stall_cnt_d  = bubble ? stall_cnt_q + 32'd1 : stall_cnt_q;
    retire_cnt_d = wb_q.valid ? retire_cnt_q + 32'd1 : retire_cnt_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign retire_cnt = retire_cnt_q;
`else
  assign stall_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed bench for pipe_ctrl_chain: reset, flow, load-use bubble, jal, store, perf counters.
module tb_pipe_ctrl_chain;
  import pipe_pkg::*;

  logic              clock = 1'b0;
  logic              resetn;
  logic              wpcir, wreg, m2reg, wmem, jal, regrt, aluimm, shift;
  logic [ALUC_W-1:0] aluc;
  logic [RN_W-1:0]   rt, rd;
  logic              ewreg, em2reg, ewmem, ejal, ealuimm, eshift;
  logic [ALUC_W-1:0] ealuc;
  logic [RN_W-1:0]   ern, mrn, wrn;
  logic              mwreg, mm2reg, mwmem, wwreg, wm2reg;
  logic              evalid, mvalid, wvalid;
  logic [31:0]       stall_cnt, retire_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pipe_ctrl_chain dut (
    .clock      (clock),
    .resetn     (resetn),
    .wpcir      (wpcir),
    .wreg       (wreg),
    .m2reg      (m2reg),
    .wmem       (wmem),
    .jal        (jal),
    .regrt      (regrt),
    .aluimm     (aluimm),
    .shift      (shift),
    .aluc       (aluc),
    .rt         (rt),
    .rd         (rd),
    .ewreg      (ewreg),
    .em2reg     (em2reg),
    .ewmem      (ewmem),
    .ejal       (ejal),
    .ealuimm    (ealuimm),
    .eshift     (eshift),
    .ealuc      (ealuc),
    .ern        (ern),
    .mwreg      (mwreg),
    .mm2reg     (mm2reg),
    .mwmem      (mwmem),
    .mrn        (mrn),
    .wwreg      (wwreg),
    .wm2reg     (wm2reg),
    .wrn        (wrn),
    .evalid     (evalid),
    .mvalid     (mvalid),
    .wvalid     (wvalid),
    .stall_cnt  (stall_cnt),
    .retire_cnt (retire_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic id_nop();
    wreg = 0; m2reg = 0; wmem = 0; jal = 0; regrt = 0;
    aluimm = 0; shift = 0; aluc = '0; rt = '0; rd = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    logic [63:0] v;
    v = {ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern, mwreg, mm2reg, mwmem, mrn,
         wwreg, wm2reg, wrn, evalid, mvalid, wvalid, stall_cnt | retire_cnt};
    chk(tag, v[31:0] | {31'd0, |v[63:32]}, 32'd0);
  endtask

  initial begin
    // Reset held with an active writing instruction at ID.
    resetn = 0; wpcir = 1;
    id_nop(); wreg = 1; rd = 5'd5;
    repeat (3) step();
    chk_all_zero("reset_hold");
    @(negedge clock);
    resetn = 1;
    #1;
    chk_all_zero("reset_release_mid");
    step();
    chk("rst_ern", ern, 5);
    chk("rst_ewreg", ewreg, 1);
    chk("rst_evalid", evalid, 1);

    // Add flow: rd=9 walks through EXE, MEM, WB.
    id_nop(); wreg = 1; rd = 5'd9;
    step();
    chk("add_ern", ern, 9);
    chk("add_mrn_prev", mrn, 5);
    id_nop();
    step();
    chk("nop_ern", ern, 0);
    chk("nop_evalid", evalid, 1);
    chk("add_mrn", mrn, 9);
    chk("add_mvalid", mvalid, 1);
    step();
    chk("add_wrn", wrn, 9);
    chk("add_wwreg", wwreg, 1);
    chk("add_wvalid", wvalid, 1);

    // Load-use: lw rt=8 then one stall cycle.
    id_nop(); wreg = 1; m2reg = 1; regrt = 1; rt = 5'd8; rd = 5'd17;
    step();
    chk("lw_ern", ern, 8);
    chk("lw_em2reg", em2reg, 1);
    wpcir = 0;
    step();
    chk("lu_bubble_ewreg", ewreg, 0);
    chk("lu_bubble_ern", ern, 0);
    chk("lu_bubble_evalid", evalid, 0);
    chk("lu_bubble_em2reg", em2reg, 0);
    chk("lu_mrn", mrn, 8);
    chk("lu_mm2reg", mm2reg, 1);
    wpcir = 1; id_nop();
    step();
    chk("lu_wrn", wrn, 8);
    chk("lu_wm2reg", wm2reg, 1);
    chk("lu_mvalid_bubble", mvalid, 0);
    chk("lu_mrn_bubble", mrn, 0);
    step();
    chk("lu_wvalid_bubble", wvalid, 0);

    // jal writes the link register; without wreg the destination reads 0.
    id_nop(); jal = 1; wreg = 1; rd = 5'd3;
    step();
    chk("jal_ern", ern, 31);
    chk("jal_ejal", ejal, 1);
    id_nop(); jal = 1; wreg = 0; rd = 5'd7;
    step();
    chk("jal_nowreg_ern", ern, 0);
    chk("jal_nowreg_ejal", ejal, 1);
    id_nop(); jal = 1; wreg = 1; rd = 5'd3; wpcir = 0;
    step();
    chk("jal_stall_ejal", ejal, 0);
    chk("jal_stall_ern", ern, 0);
    chk("jal_stall_ewreg", ewreg, 0);

    // Store: rt selected but not written.
    wpcir = 1;
    id_nop(); wmem = 1; regrt = 1; rt = 5'd4;
    step();
    chk("st_ewmem", ewmem, 1);
    chk("st_ern", ern, 0);
    id_nop();
    step();
    chk("st_mwmem", mwmem, 1);
    chk("st_mrn", mrn, 0);

    // ALU operand controls captured, then cleared by consecutive stalls.
    id_nop(); aluimm = 1; shift = 1; aluc = 4'hA; wreg = 1; regrt = 1; rt = 5'd12;
    step();
    chk("alu_fields", {ealuimm, eshift, ealuc}, {1'b1, 1'b1, 4'hA});
    chk("alu_ern", ern, 12);
    wpcir = 0;
    step();
    chk("stall1_fields", {ealuimm, eshift, ealuc, evalid}, 0);
    step();
    chk("stall2_evalid", evalid, 0);
    chk("stall2_mvalid", mvalid, 0);
    chk("stall2_wrn", wrn, 12);

    // Counters: reset, 10 valid issues, then 3 stalls.
    resetn = 0;
    #2;
    chk_all_zero("reset_again");
    @(negedge clock);
    resetn = 1;
    id_nop(); wreg = 1; rd = 5'd1; wpcir = 1;
    repeat (10) step();
    wpcir = 0;
    repeat (3) step();
`ifdef PIPE_PERF_EN
    chk("perf_stall_cnt", stall_cnt, 3);
    chk("perf_retire_cnt", retire_cnt, 10);
`else
    chk("perf_stall_tied", stall_cnt, 0);
    chk("perf_retire_tied", retire_cnt, 0);
`endif
    chk("drain_wvalid", wvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
